// File: rtl/rvfi_obi_mem_model.sv
// Memory-side responder for formal wrappers: turns free-running random inputs into
// protocol-legal OBI grant/response traffic per channel and flags core-side request instability.
module rvfi_obi_mem_model #(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUT         = 2,
    parameter int unsigned FAIR            = 1,
    parameter int unsigned MAX_GNT_WAIT    = 3,
    parameter int unsigned MAX_RVALID_WAIT = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [NUM_CH*ADDR_W-1:0]   addr_i,
    input  logic [NUM_CH-1:0]          we_i,
    input  logic [NUM_CH*DATA_W/8-1:0] be_i,
    input  logic [NUM_CH*DATA_W-1:0]   wdata_i,
    input  logic [NUM_CH-1:0]          rand_gnt_i,
    input  logic [NUM_CH-1:0]          rand_rvalid_i,
    input  logic [NUM_CH*DATA_W-1:0]   rand_rdata_i,
    output logic [NUM_CH-1:0]          gnt_o,
    output logic [NUM_CH-1:0]          rvalid_o,
    output logic [NUM_CH*DATA_W-1:0]   rdata_o,
    output logic [NUM_CH*ADDR_W-1:0]   rsp_addr_o,
    output logic [NUM_CH-1:0]          rsp_we_o,
    output logic [NUM_CH*4-1:0]        out_cnt_o,
    output logic [NUM_CH-1:0]          err_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned GW_W  = (MAX_GNT_WAIT > 0) ? $clog2(MAX_GNT_WAIT + 1) : 1;
    localparam int unsigned RW_W  = (MAX_RVALID_WAIT > 0) ? $clog2(MAX_RVALID_WAIT + 1) : 1;
    localparam logic        FAIR_EN = (FAIR != 0);

    // FIFO pointer increment, wrapping at MAX_OUT which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [3:0]        out_cnt;
        logic [GW_W-1:0]   gnt_wait;
        logic [RW_W-1:0]   rv_wait;
        logic [PTR_W-1:0]  wptr;
        logic [PTR_W-1:0]  rptr;
        logic [ADDR_W-1:0] fifo_addr [MAX_OUT];
        logic              fifo_we   [MAX_OUT];
        logic              pending;
        logic              err;
        logic [ADDR_W-1:0] cap_addr;
        logic              cap_we;
        logic [BE_W-1:0]   cap_be;
        logic [DATA_W-1:0] cap_wdata;

        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              can_gnt;
        logic              gnt;
        logic              rvalid;
        logic              head_we;
        logic              violation;

        assign addr  = addr_i[c*ADDR_W +: ADDR_W];
        assign be    = be_i[c*BE_W +: BE_W];
        assign wdata = wdata_i[c*DATA_W +: DATA_W];

        // can_gnt uses the registered count: a same-cycle response never frees a slot early
        assign can_gnt = out_cnt < 4'(MAX_OUT);
        assign gnt     = req_i[c] & can_gnt
                       & (rand_gnt_i[c] | (FAIR_EN & (gnt_wait == GW_W'(MAX_GNT_WAIT))));
        assign rvalid  = (out_cnt != 4'd0)
                       & (rand_rvalid_i[c] | (FAIR_EN & (rv_wait == RW_W'(MAX_RVALID_WAIT))));
        assign head_we = fifo_we[rptr];

        assign violation = pending & (~req_i[c] | (addr != cap_addr) | (we_i[c] != cap_we)
                                      | (be != cap_be) | (wdata != cap_wdata));

        assign gnt_o[c]                      = gnt;
        assign rvalid_o[c]                   = rvalid;
        assign rsp_addr_o[c*ADDR_W +: ADDR_W] = rvalid ? fifo_addr[rptr] : '0;
        assign rsp_we_o[c]                   = rvalid & head_we;
        assign rdata_o[c*DATA_W +: DATA_W]   = (rvalid & ~head_we) ? rand_rdata_i[c*DATA_W +: DATA_W] : '0;
        assign out_cnt_o[c*4 +: 4]           = out_cnt;
        assign err_o[c]                      = err;

        // Control state: counts, wait timers, pointers and the sticky checker flag
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                out_cnt  <= 4'd0;
                gnt_wait <= '0;
                rv_wait  <= '0;
                wptr     <= '0;
                rptr     <= '0;
                pending  <= 1'b0;
                err      <= 1'b0;
            end else begin
                if (gnt && !rvalid) begin
                    out_cnt <= out_cnt + 4'd1;
                end else if (!gnt && rvalid) begin
                    out_cnt <= out_cnt - 4'd1;
                end

                if (gnt || !req_i[c]) begin
                    gnt_wait <= '0;
                end else if (gnt_wait != GW_W'(MAX_GNT_WAIT)) begin
                    gnt_wait <= gnt_wait + GW_W'(1);
                end

                if (rvalid || (out_cnt == 4'd0)) begin
                    rv_wait <= '0;
                end else if (rv_wait != RW_W'(MAX_RVALID_WAIT)) begin
                    rv_wait <= rv_wait + RW_W'(1);
                end

                if (gnt) begin
                    wptr <= ptr_inc(wptr);
                end
                if (rvalid) begin
                    rptr <= ptr_inc(rptr);
                end

                pending <= req_i[c] & ~gnt;
                if (violation) begin
                    err <= 1'b1;
                end
            end
        end

        // Payload storage; only meaningful while qualified by pointers or pending
        always_ff @(posedge clk_i) begin
            if (gnt) begin
                fifo_addr[wptr] <= addr;
                fifo_we[wptr]   <= we_i[c];
            end
            if (req_i[c] && !gnt) begin
                cap_addr  <= addr;
                cap_we    <= we_i[c];
                cap_be    <= be;
                cap_wdata <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_obi_mem_model.sv
// Randomized scoreboard bench for rvfi_obi_mem_model against a queue-based reference model.
module tb_rvfi_obi_mem_model;

    localparam int NUM_CH = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BW     = DW / 8;
    localparam int MAXO   = 2;
    localparam int MGW    = 3;
    localparam int MRW    = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
    } txn_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    req, we, rg, rv;
    logic [NUM_CH*AW-1:0] addr;
    logic [NUM_CH*BW-1:0] be;
    logic [NUM_CH*DW-1:0] wdata, rdata;

    logic [NUM_CH-1:0]    gnt_o, rvalid_o, rsp_we_o, err_o;
    logic [NUM_CH*DW-1:0] rdata_o;
    logic [NUM_CH*AW-1:0] rsp_addr_o;
    logic [NUM_CH*4-1:0]  out_cnt_o;

    rvfi_obi_mem_model #(
        .NUM_CH(NUM_CH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MAXO),
        .FAIR(1), .MAX_GNT_WAIT(MGW), .MAX_RVALID_WAIT(MRW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .rand_gnt_i(rg), .rand_rvalid_i(rv), .rand_rdata_i(rdata),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rsp_addr_o(rsp_addr_o),
        .rsp_we_o(rsp_we_o), .out_cnt_o(out_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    txn_t          mq  [NUM_CH][$];
    txn_t          sbq [NUM_CH][$];
    int            gw [NUM_CH];
    int            rw [NUM_CH];
    bit            pend [NUM_CH];
    bit            merr [NUM_CH];
    logic [AW-1:0] c_addr [NUM_CH];
    logic          c_we [NUM_CH];
    logic [BW-1:0] c_be [NUM_CH];
    logic [DW-1:0] c_wdata [NUM_CH];
    bit            flush = 0;
    bit            mon_en = 0;
    int            gprob = 50;
    int            vprob = 50;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            gw[c]   = 0;
            rw[c]   = 0;
            pend[c] = 0;
            merr[c] = 0;
        end
    endtask

    // Evaluate one cycle: compare control outputs, push expected responses, advance model
    task automatic step();
        int n;
        bit eg, ev, viol;
        txn_t t;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            n  = mq[c].size();
            eg = req[c] && (n < MAXO) && (rg[c] || gw[c] >= MGW);
            ev = (n != 0) && (rv[c] || rw[c] >= MRW);
            check($sformatf("gnt[%0d]", c), 64'(gnt_o[c]), 64'(eg));
            check($sformatf("rvalid[%0d]", c), 64'(rvalid_o[c]), 64'(ev));
            check($sformatf("out_cnt[%0d]", c), 64'(out_cnt_o[c*4 +: 4]), 64'(n));
            check($sformatf("err[%0d]", c), 64'(err_o[c]), 64'(merr[c]));
            t.addr = addr[c*AW +: AW];
            t.we   = we[c];
            if (eg) sbq[c].push_back(t);
            if (rst_n) begin
                viol = pend[c] && (!req[c] || t.addr != c_addr[c] || t.we != c_we[c]
                                   || be[c*BW +: BW] != c_be[c] || wdata[c*DW +: DW] != c_wdata[c]);
                if (viol) merr[c] = 1;
                if (ev) void'(mq[c].pop_front());
                if (eg) mq[c].push_back(t);
                gw[c] = (req[c] && !eg) ? ((gw[c] + 1 > MGW) ? MGW : gw[c] + 1) : 0;
                rw[c] = (n != 0 && !ev) ? ((rw[c] + 1 > MRW) ? MRW : rw[c] + 1) : 0;
                pend[c] = req[c] && !eg;
                if (pend[c]) begin
                    c_addr[c]  = t.addr;
                    c_we[c]    = t.we;
                    c_be[c]    = be[c*BW +: BW];
                    c_wdata[c] = wdata[c*DW +: DW];
                end
            end
        end
        if (!rst_n) begin
            model_clear();
            flush = 1;
        end
        mon_en = 1;
    endtask

    task automatic cycle_begin();
        @(posedge clk);
        #1;
        if (flush) begin
            for (int c = 0; c < NUM_CH; c++) sbq[c].delete();
            flush = 0;
        end
    endtask

    // Mostly-compliant random channel stimulus: a pending request is usually held stable
    task automatic gen_ch(input int c);
        if (!(pend[c] && $urandom_range(39) != 0)) begin
            req[c]           = ($urandom_range(3) != 0);
            addr[c*AW +: AW] = $urandom;
            we[c]            = $urandom_range(1) == 1;
            be[c*BW +: BW]   = BW'($urandom);
            wdata[c*DW +: DW] = $urandom;
        end
        rg[c]             = $urandom_range(99) < gprob;
        rv[c]             = $urandom_range(99) < vprob;
        rdata[c*DW +: DW] = $urandom;
    endtask

    task automatic dir0(input logic r, input logic [31:0] a, input logic g, input logic v,
                        input logic rs);
        cycle_begin();
        gen_ch(1);
        rst_n     = rs;
        req[0]    = r;
        addr[0 +: AW] = a;
        we[0]     = 1'b0;
        be[0 +: BW] = '1;
        wdata[0 +: DW] = '0;
        rg[0]     = g;
        rv[0]     = v;
        rdata[0 +: DW] = $urandom;
        step();
    endtask

    // Response monitor: pops the scoreboard whenever the DUT presents a response
    always @(negedge clk) begin
        txn_t t;
        if (mon_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rvalid_o[c]) begin
                    if (sbq[c].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rsp_unexpected[%0d] @%0t: got rvalid 1 expected no outstanding", c, $time);
                    end else begin
                        t = sbq[c].pop_front();
                        check($sformatf("rsp_addr[%0d]", c), 64'(rsp_addr_o[c*AW +: AW]), 64'(t.addr));
                        check($sformatf("rsp_we[%0d]", c), 64'(rsp_we_o[c]), 64'(t.we));
                        check($sformatf("rdata[%0d]", c), 64'(rdata_o[c*DW +: DW]),
                              t.we ? 64'd0 : 64'(rdata[c*DW +: DW]));
                    end
                end else begin
                    check($sformatf("idle_rsp[%0d]", c),
                          {31'd0, rsp_we_o[c], rsp_addr_o[c*AW +: AW] | rdata_o[c*DW +: DW]}, 64'd0);
                end
            end
        end
    end

    initial begin
        int gp [6] = '{100, 0, 30, 70, 0, 50};
        int vp [6] = '{0, 100, 30, 0, 0, 60};
        rst_n = 0; req = '0; we = '0; rg = '0; rv = '0;
        addr = '0; be = '0; wdata = '0; rdata = '0;
        model_clear();

        dir0(0, 32'h0, 1, 0, 0);
        dir0(0, 32'h0, 1, 0, 0);
        // no request: no grant despite constant random grant
        dir0(0, 32'h0, 1, 0, 1);
        dir0(0, 32'h0, 1, 0, 1);
        // two grants fill the channel, third waits; then in-order drain with same-cycle gnt/rvalid
        dir0(1, 32'h100, 1, 0, 1);
        dir0(1, 32'h104, 1, 0, 1);
        dir0(1, 32'h108, 1, 0, 1);
        dir0(1, 32'h108, 1, 1, 1);
        dir0(1, 32'h108, 1, 1, 1);
        dir0(0, 32'h0, 0, 1, 1);
        dir0(0, 32'h0, 0, 0, 1);
        // forced grant on 4th request cycle, forced rvalid on 4th outstanding cycle
        for (int i = 0; i < 4; i++) dir0(1, 32'h300, 0, 0, 1);
        for (int i = 0; i < 6; i++) dir0(0, 32'h0, 0, 0, 1);
        // instability: address changes while ungranted, error must stick until reset
        dir0(1, 32'h200, 0, 0, 1);
        dir0(1, 32'h204, 0, 0, 1);
        for (int i = 0; i < 3; i++) dir0(0, 32'h0, 0, 0, 1);
        // reset with two outstanding entries discards them
        dir0(1, 32'h400, 1, 0, 1);
        dir0(1, 32'h404, 1, 0, 1);
        dir0(0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 3; i++) dir0(0, 32'h0, 0, 1, 1);

        for (int ph = 0; ph < 6; ph++) begin
            gprob = gp[ph];
            vprob = vp[ph];
            for (int i = 0; i < 500; i++) begin
                cycle_begin();
                rst_n = ($urandom_range(149) != 0);
                for (int c = 0; c < NUM_CH; c++) gen_ch(c);
                step();
            end
        end

        @(posedge clk);
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
